// File: rtl/uart_tx_serializer.sv
// UART transmitter: one byte per ready/enable handshake, sent LSB first as 8N1/8N2.
// Defining UART_TX_PARITY_EN adds an even-parity bit after the data (8E1/8E2).
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 36,
   parameter int STOP_BITS    = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] uart_data,
   input  logic       uart_clock_enable,
   output logic       uart_ready,
   output logic       tx,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP
   } state_t;
`endif

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic          armed;
   logic          stop_n;
   logic          bit_end;
`ifdef UART_TX_PARITY_EN
   logic          par;
`endif

   assign bit_end = (cnt == LAST);

   // Frame sequencer; tx/uart_ready/busy are registered alongside state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shift      <= '0;
         armed      <= 1'b1;
         stop_n     <= 1'b0;
         tx         <= 1'b1;
         uart_ready <= 1'b1;
         busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         // A dropped enable re-arms, so a held enable sends a byte only once.
         if (!uart_clock_enable)
            armed <= 1'b1;

         if (state != IDLE) begin
            if (bit_end)
               cnt <= '0;
            else
               cnt <= cnt + 1'b1;
         end

         unique case (state)
            IDLE: begin
               tx <= 1'b1;
               if (uart_clock_enable && uart_ready && armed) begin
                  shift      <= uart_data;
                  armed      <= 1'b0;
                  uart_ready <= 1'b0;
                  busy       <= 1'b1;
                  tx         <= 1'b0;
                  cnt        <= '0;
                  state      <= START;
`ifdef UART_TX_PARITY_EN
                  par        <= ^uart_data;
`endif
               end
            end
            START: begin
               if (bit_end) begin
                  idx   <= '0;
                  tx    <= shift[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift <= shift >> 1;
                  if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= par;
                     state <= PARITY;
`else
                     tx     <= 1'b1;
                     stop_n <= 1'b0;
                     state  <= STOP;
`endif
                  end else begin
                     idx <= idx + 3'd1;
                     tx  <= shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  tx     <= 1'b1;
                  stop_n <= 1'b0;
                  state  <= STOP;
               end
            end
`endif
            STOP: begin
               tx <= 1'b1;
               if (bit_end) begin
                  if (stop_n != LAST_STOP) begin
                     stop_n <= stop_n + 1'b1;
                  end else begin
                     uart_ready <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
